ring_johnson_counter: RTL and testbench

Parametrised shift-pattern counter, the successor to the fixed 4-bit ring counter. It supports ring (one-hot rotate) and Johnson (twisted-ring) modes, both shift directions, run-time load, clock enable, and self-correction of illegal states. It serves as the sequencer/phase generator for multi-phase control logic and stepper-style output stages, with a wrap pulse for cascading.

---
 rtl/ring_counter_pkg.sv | 47 ++++
 rtl/ring_counter_legal_check.sv | 21 ++
 rtl/ring_johnson_counter.sv | 93 +++++++++
 tb/tb_ring_johnson_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and pattern helpers for the ring/Johnson shift counter.
// Functions work on a 32-bit container and take the active width as an argument,
// so one package serves every WIDTH instance (2..32).
package ring_counter_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  typedef logic [MAX_WIDTH-1:0] pattern_t;

  // All-ones mask covering the low `width` bits; 33-bit math keeps width=32 exact.
  function automatic pattern_t width_mask(input int unsigned width);
    logic [MAX_WIDTH:0] m;
    m = (33'd1 << width) - 33'd1;
    return m[MAX_WIDTH-1:0];
  endfunction

  // True for 2^k-1 (including 0 and all-ones): adding one clears every set bit.
  function automatic logic is_low_ones(input pattern_t p);
    logic [MAX_WIDTH:0] p_inc;
    p_inc = {1'b0, p} + 33'd1;
    return (p & p_inc[MAX_WIDTH-1:0]) == '0;
  endfunction

  // Ring: exactly one bit set. Johnson: low-ones mask or its complement (2W states).
  function automatic logic is_legal(input pattern_t pattern, input logic mode,
                                    input int unsigned width);
    pattern_t mask;
    pattern_t p;
    mask = width_mask(width);
    p    = pattern & mask;
    if (mode == MODE_RING) begin
      return (p != '0) && ((p & (p - pattern_t'(1))) == '0);
    end
    return is_low_ones(p) || is_low_ones(~p & mask);
  endfunction

  // Sequence origin: 0..01 for ring, all zeros for Johnson.
  function automatic pattern_t home_pattern(input logic mode, input int unsigned width);
    return (mode == MODE_RING) ? (pattern_t'(1) & width_mask(width)) : '0;
  endfunction

endpackage

// File: rtl/ring_counter_legal_check.sv
// Purely combinational legality and home-pattern decode for one counter value.
// Zero latency; no handshake, output follows pattern_i/mode_i directly.
// Shared by the illegal output and by the step logic of the counter.
module ring_counter_legal_check
  import ring_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             mode_i,
  output logic             legal_o,
  output logic [WIDTH-1:0] home_o
);

  // Decode legality and home pattern for the currently selected mode.
  always_comb begin
    legal_o = is_legal(pattern_t'(pattern_i), mode_i, WIDTH);
    home_o  = WIDTH'(home_pattern(mode_i, WIDTH));
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift counter with load, enable, wrap pulse and self-correction.
// One-cycle latency from sampled inputs to out/wrap/fault; illegal is combinational.
// No backpressure: en=0 simply holds the pattern.
module ring_johnson_counter
  import ring_counter_pkg::*;
#(
  parameter int unsigned           WIDTH         = 4,
  parameter logic [WIDTH-1:0]      RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             illegal,
  output logic             fault
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             fault_q, fault_d;
  logic             cur_legal;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] shifted;
  logic             init_legal;

  // Single legality decode of the live value, used for both illegal and correction.
  ring_counter_legal_check #(
    .WIDTH(WIDTH)
  ) u_legal (
    .pattern_i(out_q),
    .mode_i   (mode),
    .legal_o  (cur_legal),
    .home_o   (home)
  );

  // Candidate next pattern for a normal step in the sampled mode and direction.
  always_comb begin
    shifted = out_q;
    case ({mode, dir})
      {MODE_RING,    DIR_LEFT}:  shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      {MODE_RING,    DIR_RIGHT}: shifted = {out_q[0], out_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT}:  shifted = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_RIGHT}: shifted = {~out_q[0], out_q[WIDTH-1:1]};
      default:                   shifted = out_q;
    endcase
  end

  // Next-state mux: load beats step; an illegal value is replaced by home instead of shifted.
  always_comb begin
    out_d      = out_q;
    wrap_d     = 1'b0;
    fault_d    = fault_q;
    init_legal = is_legal(pattern_t'(init), mode, WIDTH);
    if (load) begin
      out_d = init;
      if (init_legal) begin
        fault_d = 1'b0;
      end
    end else if (en) begin
      if (!cur_legal) begin
        out_d   = home;
        fault_d = 1'b1;
      end else begin
        out_d  = shifted;
        wrap_d = (shifted == home);
      end
    end
  end

  // State, wrap and sticky fault registers; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_PATTERN;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign out     = out_q;
  assign wrap    = wrap_q;
  assign fault   = fault_q;
  assign illegal = ~cur_legal;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Bench for ring_johnson_counter: WIDTH=4 and WIDTH=8 instances share control inputs
// and are compared every cycle against a sequence-index model of the counter.
module tb_ring_johnson_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, en = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0;
  logic [3:0] init4 = '0, out4;
  logic [7:0] init8 = '0, out8;
  logic       wrap4, illegal4, fault4;
  logic       wrap8, illegal8, fault8;

  ring_johnson_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .load(load), .init(init4), .mode(mode), .dir(dir),
    .out(out4), .wrap(wrap4), .illegal(illegal4), .fault(fault4)
  );

  ring_johnson_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .load(load), .init(init8), .mode(mode), .dir(dir),
    .out(out8), .wrap(wrap8), .illegal(illegal8), .fault(fault8)
  );

  int checks   = 0;
  int failures = 0;
  int wrap_cnt8 = 0;

  // Reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
  logic [31:0] m_out [2];
  logic        m_wrap [2];
  logic        m_fault [2];
  bit          m_valid = 1'b0;
  int          wid [2] = '{4, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int period(input logic md, input int w);
    return md ? 2 * w : w;
  endfunction

  // k-th pattern of the left-stepping sequence starting at home.
  function automatic logic [31:0] seq_state(input logic md, input int w, input int k);
    logic [31:0] full;
    full = (32'd1 << w) - 32'd1;
    if (!md) return 32'd1 << k;
    if (k <= w) return (32'd1 << k) - 32'd1;
    return full ^ ((32'd1 << (k - w)) - 32'd1);
  endfunction

  // Position of a pattern in its mode's sequence, or -1 when it is not a legal state.
  function automatic int find_index(input logic [31:0] pat, input logic md, input int w);
    for (int k = 0; k < period(md, w); k++) begin
      if (seq_state(md, w, k) == pat) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int i, input logic [31:0] initv);
    int k, n, k2;
    if (reset) begin
      m_out[i] = 32'd1; m_wrap[i] = 1'b0; m_fault[i] = 1'b0;
      m_valid  = 1'b1;
    end else if (load) begin
      m_out[i] = initv; m_wrap[i] = 1'b0;
      if (find_index(initv, mode, wid[i]) >= 0) m_fault[i] = 1'b0;
    end else if (en) begin
      k = find_index(m_out[i], mode, wid[i]);
      if (k < 0) begin
        m_out[i] = seq_state(mode, wid[i], 0); m_fault[i] = 1'b1; m_wrap[i] = 1'b0;
      end else begin
        n  = period(mode, wid[i]);
        k2 = dir ? (k + n - 1) % n : (k + 1) % n;
        m_out[i]  = seq_state(mode, wid[i], k2);
        m_wrap[i] = (k2 == 0);
      end
    end else begin
      m_wrap[i] = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already driven; checks illegal, then the edge result.
  task automatic tick();
    #1;
    if (m_valid) begin
      chk("illegal4", 32'(illegal4), 32'(find_index(m_out[0], mode, 4) < 0));
      chk("illegal8", 32'(illegal8), 32'(find_index(m_out[1], mode, 8) < 0));
    end
    model_update(0, 32'(init4));
    model_update(1, 32'(init8));
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("out4", 32'(out4), m_out[0]);
      chk("wrap4", 32'(wrap4), 32'(m_wrap[0]));
      chk("fault4", 32'(fault4), 32'(m_fault[0]));
      chk("out8", 32'(out8), m_out[1]);
      chk("wrap8", 32'(wrap8), 32'(m_wrap[1]));
      chk("fault8", 32'(fault8), 32'(m_fault[1]));
    end
    if (wrap8 === 1'b1) wrap_cnt8++;
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic md,
                       input logic d, input logic [7:0] iv);
    reset = r; load = l; en = e; mode = md; dir = d;
    init4 = iv[3:0]; init8 = iv;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Reset, then ring left through one full period.
    drive(1, 0, 0, 0, 0, 8'h00); tick();
    chk("reset_out4", 32'(out4), 32'h1);
    chk("reset_fault4", 32'(fault4), 32'h0);
    drive(0, 0, 1, 0, 0, 8'h00); repeat (4) tick();
    chk("ring_left_home4", 32'(out4), 32'h1);
    chk("ring_left_wrap4", 32'(wrap4), 32'h1);

    // Load 0010, ring right, hold three cycles at 1000, continue.
    drive(0, 1, 0, 0, 1, 8'h02); tick();
    drive(0, 0, 1, 0, 1, 8'h00); repeat (2) tick();
    drive(0, 0, 0, 0, 1, 8'h00); repeat (3) tick();
    chk("hold4", 32'(out4), 32'h8);
    drive(0, 0, 1, 0, 1, 8'h00); repeat (2) tick();

    // Johnson left then right from all zeros.
    drive(0, 1, 0, 1, 0, 8'h00); tick();
    drive(0, 0, 1, 1, 0, 8'h00); repeat (8) tick();
    chk("johnson_left_home4", 32'(out4), 32'h0);
    drive(0, 0, 1, 1, 1, 8'h00); repeat (8) tick();

    // Illegal ring load, correction, fault cleared by a legal load.
    drive(0, 1, 0, 0, 0, 8'h06); tick();
    drive(0, 0, 1, 0, 0, 8'h00); tick();
    chk("correct_out4", 32'(out4), 32'h1);
    chk("correct_fault4", 32'(fault4), 32'h1);
    drive(0, 1, 0, 0, 0, 8'h04); tick();
    chk("fault_clear4", 32'(fault4), 32'h0);

    // Johnson 0011 then switch to ring; load beats en; reset mid-run.
    drive(0, 1, 0, 1, 0, 8'h00); tick();
    drive(0, 0, 1, 1, 0, 8'h00); repeat (2) tick();
    drive(0, 0, 1, 0, 0, 8'h00); tick();
    drive(0, 1, 1, 0, 0, 8'h08); tick();
    chk("load_wins4", 32'(out4), 32'h8);
    drive(0, 0, 1, 0, 0, 8'h00); repeat (2) tick();
    drive(1, 1, 1, 0, 0, 8'h08); tick();
    chk("midrun_reset4", 32'(out4), 32'h1);

    // WIDTH=8 periods: one wrap per 8 ring steps and per 16 Johnson steps.
    drive(0, 1, 0, 0, 0, 8'h01); tick();
    wrap_cnt8 = 0;
    drive(0, 0, 1, 0, 0, 8'h00); repeat (8) tick();
    chk("ring_period8_wraps", 32'(wrap_cnt8), 32'd1);
    chk("ring_period8_out", 32'(out8), 32'h01);
    drive(0, 1, 0, 1, 0, 8'h00); tick();
    wrap_cnt8 = 0;
    drive(0, 0, 1, 1, 0, 8'h00); repeat (16) tick();
    chk("johnson_period8_wraps", 32'(wrap_cnt8), 32'd1);
    chk("johnson_period8_out", 32'(out8), 32'h00);

    // Randomized traffic with occasional mode/dir changes, loads and resets.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) dir  = 1'($urandom_range(0, 1));
      init4 = 4'($urandom);
      init8 = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
